// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    // Number of data bits in one 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Level of the serial line when nothing is being sent.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RESET_VALUE lets the caller choose the level seen while in reset, so an
// idle-high serial line does not look like a start bit coming out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a mid-bit sampler.
//
// Valid/strobe semantics: there is no back-pressure. rx_valid is a one-cycle
// pulse that marks the cycle in which data_out first shows a newly received
// byte; frame_error is a one-cycle pulse for a frame whose stop bit sampled
// low. The two pulses never coincide and data_out only changes with rx_valid.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_line,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      rx_valid,
    output logic                      frame_error,
    output logic                      rx_busy
);

    // Offset from the start-bit edge to its middle; fixed by CLKS_PER_BIT.
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    // Terminal counts: the sample happens on the edge where the counter
    // holds these values, so a wait of N cycles ends at N-1.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_sync;
    uart_state_e               state;
    logic [CNT_W-1:0]          cycle_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_reg;

    // The line idles high, so the synchronizer resets to the idle level.
    sync_2ff #(
        .RESET_VALUE (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_line),
        .q     (rx_sync)
    );

    // Frame FSM, cycle/bit counters, shift register and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cycle_cnt   <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                    if (rx_sync != UART_IDLE_LEVEL) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cycle_cnt == HALF_LAST) begin
                        cycle_cnt <= '0;
                        if (rx_sync == UART_IDLE_LEVEL) begin
                            // Line went back high before mid-bit: a glitch.
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= '0;
                        shift_reg <= {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= '0;
                        if (rx_sync == UART_IDLE_LEVEL) begin
                            data_out <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            // Bad stop bit: keep the previous byte and wait
                            // for the line to recover before re-arming.
                            frame_error <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    cycle_cnt <= '0;
                    if (rx_sync == UART_IDLE_LEVEL) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule
